// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronised line, falling-edge start detect, mid-bit sampling.
// Latency: o_valid 2 + HALF_BIT + 9*CLKS_PER_BIT (+/-1) cycles after the start edge on i_rx.
// No backpressure: o_data/o_valid are a fire-and-forget strobe; consumer must take it.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic             rx_meta_q;
  logic             rx_s_q;
  logic             rx_prev_q;
  state_t           state_q;
  logic [CNT_W-1:0] clk_cnt_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             ferr_q;

  // Synchronise the asynchronous line and keep a one-cycle history for edge detection.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  // Frame FSM: start-bit qualification, data shifting, stop-bit check and output strobes.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          // Only a high-to-low transition arms a frame; a held-low line is ignored.
          if (rx_prev_q && !rx_s_q) begin
            state_q   <= START;
            clk_cnt_q <= '0;
          end
        end
        START: begin
          if (clk_cnt_q == CNT_HALF) begin
            clk_cnt_q <= '0;
            if (!rx_s_q) begin
              state_q   <= DATA;
              bit_cnt_q <= '0;
            end else begin
              // Line went back high before mid start bit: treat as a glitch.
              state_q <= IDLE;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_ONE;
          end
        end
        DATA: begin
          if (clk_cnt_q == CNT_LAST) begin
            clk_cnt_q <= '0;
            shift_q   <= {rx_s_q, shift_q[7:1]};
            if (bit_cnt_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_ONE;
          end
        end
        STOP: begin
          // Leaving at mid stop bit leaves half a bit of slack to catch a back-to-back start edge.
          if (clk_cnt_q == CNT_LAST) begin
            clk_cnt_q <= '0;
            state_q   <= IDLE;
            if (rx_s_q) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              ferr_q <= 1'b1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CNT_ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=8: loopback byte, back-to-back frames, glitch,
// framing error with held-low line, and reset mid-frame. Bus-functional transmitter task
// drives the line on the falling clock edge; a monitor logs every strobe on the falling edge.
module tb_uart_rx;

  localparam int CPB = 8;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_rx  = 1'b1;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_busy;

  int n_checks = 0;
  int n_err    = 0;

  int         cyc = 0;
  int         t_fall = 0;
  int         lat_last = -1;
  logic [7:0] rx_q[$];
  int         n_ferr = 0;
  int         n_both = 0;
  int         n_wide_vld = 0;
  int         n_wide_ferr = 0;
  logic       prev_vld = 1'b0;
  logic       prev_ferr = 1'b0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_rx       (i_rx),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_frame_err(o_frame_err),
    .o_busy     (o_busy)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc = cyc + 1;

  // Strobe monitor, sampled mid-cycle.
  always @(negedge i_clk) begin
    if (o_valid) begin
      rx_q.push_back(o_data);
      lat_last = cyc - t_fall;
    end
    if (o_frame_err) n_ferr = n_ferr + 1;
    if (o_valid && o_frame_err) n_both = n_both + 1;
    if (o_valid && prev_vld) n_wide_vld = n_wide_vld + 1;
    if (o_frame_err && prev_ferr) n_wide_ferr = n_wide_ferr + 1;
    prev_vld  = o_valid;
    prev_ferr = o_frame_err;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called on a falling clock edge; returns on a falling edge with the line left at stop_val.
  task automatic send_frame(input logic [7:0] b, input logic stop_val);
    i_rx   = 1'b0;
    t_fall = cyc + 1;
    repeat (CPB) @(negedge i_clk);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      repeat (CPB) @(negedge i_clk);
    end
    i_rx = stop_val;
    repeat (CPB) @(negedge i_clk);
  endtask

  initial begin
    int   n_before;
    int   ferr_before;
    logic busy_seen;
    logic [7:0] b96;

    // Reset state.
    repeat (3) @(negedge i_clk);
    check_val("rst_data",  o_data,      8'h00);
    check_val("rst_valid", o_valid,     1'b0);
    check_val("rst_ferr",  o_frame_err, 1'b0);
    check_val("rst_busy",  o_busy,      1'b0);
    i_rst = 1'b1;
    repeat (20) @(negedge i_clk);

    // Single loopback-style byte.
    send_frame(8'h41, 1'b1);
    repeat (20) @(negedge i_clk);
    check_val("b41_count", rx_q.size(), 1);
    if (rx_q.size() >= 1) check_val("b41_data", rx_q[0], 8'h41);
    check_val("b41_odata", o_data, 8'h41);
    check_val("b41_ferr",  n_ferr, 0);
    check_val("b41_busy",  o_busy, 1'b0);
    check_val("b41_lat_77_79", (lat_last >= 77 && lat_last <= 79), 1'b1);
    rx_q.delete();

    // Back-to-back frames with a one-bit stop.
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'hA5, 1'b1);
    repeat (20) @(negedge i_clk);
    check_val("b2b_count", rx_q.size(), 3);
    if (rx_q.size() == 3) begin
      check_val("b2b_d0", rx_q[0], 8'h00);
      check_val("b2b_d1", rx_q[1], 8'hFF);
      check_val("b2b_d2", rx_q[2], 8'hA5);
    end
    check_val("b2b_ferr", n_ferr, 0);
    rx_q.delete();

    // Glitch shorter than half a bit.
    busy_seen = 1'b0;
    i_rx = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge i_clk);
      if (k == 2) i_rx = 1'b1;
      if (o_busy) busy_seen = 1'b1;
    end
    check_val("glitch_armed", busy_seen, 1'b1);
    check_val("glitch_idle",  o_busy,    1'b0);
    repeat (20) @(negedge i_clk);
    check_val("glitch_vld",  rx_q.size(), 0);
    check_val("glitch_ferr", n_ferr,      0);

    // Framing error, then the line stays low.
    send_frame(8'h3C, 1'b0);
    busy_seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge i_clk);
      if (o_busy) busy_seen = 1'b1;
    end
    check_val("ferr_count", n_ferr,      1);
    check_val("ferr_vld",   rx_q.size(), 0);
    check_val("ferr_hold",  o_data,      8'hA5);
    check_val("low_nobusy", busy_seen,   1'b0);
    i_rx = 1'b1;
    repeat (16) @(negedge i_clk);
    send_frame(8'h5A, 1'b1);
    repeat (20) @(negedge i_clk);
    check_val("b5a_count", rx_q.size(), 1);
    check_val("b5a_odata", o_data, 8'h5A);
    check_val("b5a_ferr",  n_ferr, 1);
    rx_q.delete();

    // Reset during bit 3 of 0x96.
    b96  = 8'h96;
    i_rx = 1'b0;
    repeat (CPB) @(negedge i_clk);
    for (int i = 0; i < 3; i++) begin
      i_rx = b96[i];
      repeat (CPB) @(negedge i_clk);
    end
    i_rx = b96[3];
    repeat (CPB / 2) @(negedge i_clk);
    check_val("mid_busy", o_busy, 1'b1);
    i_rst = 1'b0;
    #1;
    check_val("mid_rst_data",  o_data,      8'h00);
    check_val("mid_rst_busy",  o_busy,      1'b0);
    check_val("mid_rst_valid", o_valid,     1'b0);
    check_val("mid_rst_ferr",  o_frame_err, 1'b0);
    @(negedge i_clk);
    i_rx = 1'b1;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b1;
    repeat (10) @(negedge i_clk);
    check_val("post_rst_vld", rx_q.size(), 0);
    send_frame(8'h96, 1'b1);
    repeat (20) @(negedge i_clk);
    check_val("b96_count", rx_q.size(), 1);
    check_val("b96_odata", o_data, 8'h96);

    // Strobe shape across the whole run.
    check_val("excl_vld_ferr", n_both,      0);
    check_val("vld_one_cycle", n_wide_vld,  0);
    check_val("ferr_one_cycle", n_wide_ferr, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
